// File: rtl/mux_16x1.sv
// mux_16x1: registered N-to-1 bit selector built as a binary tree of 2:1 muxes, zero for out-of-range sel
module mux_16x1 #(
    parameter int DATA_WIDTH = 16,
    parameter int SEL_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic [SEL_WIDTH-1:0]  sel,
    output logic                  out
);
    localparam int N = 2 ** SEL_WIDTH;
    logic [N-1:0] leaves;
    logic         w;
    logic         out_d, out_q;
    always_comb begin
        leaves = '0;
        leaves[DATA_WIDTH-1:0] = in;
    end
    for (genvar k = 0; k <= SEL_WIDTH; k++) begin : g_lvl
        logic [(N>>k)-1:0] v;
        if (k == 0) begin : g_leaf
            assign v = leaves;
        end else begin : g_mux
            for (genvar j = 0; j < (N >> k); j++) begin : g_node
                assign v[j] = sel[k-1] ? g_lvl[k-1].v[2*j+1] : g_lvl[k-1].v[2*j];
            end
        end
    end
    assign w = g_lvl[SEL_WIDTH].v[0];
    always_comb out_d = rst ? 1'b0 : w;
    always_ff @(posedge clk) out_q <= out_d;
    assign out = out_q;
endmodule

// File: tb/tb_mux_16x1.sv
// tb_mux_16x1: directed vectors on the default and a DATA_WIDTH=10 instance, checked against an indexing model
module tb_mux_16x1;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] din;
    logic [3:0]  sel;
    logic        out1, out2;
    logic        exp1, exp2;
    logic        valid = 1'b0;
    int          checks = 0;
    int          errors = 0;

    mux_16x1 dut (.clk(clk), .rst(rst), .in(din), .sel(sel), .out(out1));
    mux_16x1 #(.DATA_WIDTH(10), .SEL_WIDTH(4)) dut2 (.clk(clk), .rst(rst), .in(din[9:0]), .sel(sel), .out(out2));

    always #5 clk = ~clk;

    function automatic logic model(logic [15:0] d, int s, int dw);
        return (s < dw) ? d[s] : 1'b0;
    endfunction

    task automatic chk(string name, logic act, logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b (sel=%0d in=%h rst=%b t=%0t)", name, act, req, sel, din, rst, $time);
        end
    endtask

    always @(posedge clk) begin
        exp1  <= rst ? 1'b0 : model(din, int'(sel), 16);
        exp2  <= rst ? 1'b0 : model(din, int'(sel), 10);
        valid <= valid | rst;
    end

    always @(posedge clk) begin
        #1;
        if (valid) begin
            chk("model_out", out1, exp1);
            chk("model_out_dw10", out2, exp2);
            chk("model_w", dut.w, model(din, int'(sel), 16));
            chk("model_w_dw10", dut2.w, model(din, int'(sel), 10));
        end
    end

    // ew/eo/eo2 < 0 skips that literal check
    task automatic step(logic [15:0] d, int s, logic r, int ew, int eo, int eo2);
        @(negedge clk);
        din = d;
        sel = s[3:0];
        rst = r;
        #1;
        if (ew >= 0) chk("lit_w", dut.w, ew[0]);
        @(posedge clk);
        #2;
        if (eo >= 0) chk("lit_out", out1, eo[0]);
        if (eo2 >= 0) chk("lit_out_dw10", out2, eo2[0]);
    endtask

    initial begin
        logic [15:0] sweep = 16'b0000_0000_0101_1001;
        int          sweep_exp [9] = '{1, 0, 0, 1, 1, 0, 1, 0, 0};
        step(16'hFFFF, 0, 1'b1, 1, 0, 0);
        step(16'hFFFF, 0, 1'b1, 1, 0, 0);
        step(16'hFFFF, 0, 1'b0, 1, 1, 1);
        for (int i = 0; i < 9; i++) step(sweep, i, 1'b0, sweep_exp[i], sweep_exp[i], sweep_exp[i]);
        step(16'h8000, 15, 1'b0, 1, 1, 0);
        step(16'h8000, 12, 1'b0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step(16'(1 << i), i, 1'b0, 1, 1, -1);
            step(16'(1 << i), i ^ 1, 1'b0, 0, 0, 0);
        end
        step(16'hFFFF, 5, 1'b0, 1, 1, 1);
        step(16'hFFFF, 5, 1'b1, 1, 0, 0);
        step(16'hFFFF, 5, 1'b0, 1, 1, 1);
        step(16'h03FF, 9, 1'b0, 1, 1, 1);
        for (int s = 10; s < 16; s++) step(16'h03FF, s, 1'b0, 0, 0, 0);
        step(16'hFC00, 10, 1'b0, 1, 1, 0);
        step(16'hFC00, 15, 1'b0, 1, 1, 0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
